// File: rtl/forwarding_scoreboard.sv
// Tracks destinations of in-flight instructions (EX..WB), raises a same-cycle load-use stall and registers EX forward selects.
// Optional FWD_PERF_EN adds saturating stall/forward performance counters; stall_ext freezes all state.
module forwarding_scoreboard #(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int SEL_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              stall_ext,
    input  logic              flush,
    output logic              stall,
    output logic [SEL_W-1:0]  fwd_a_ex,
    output logic [SEL_W-1:0]  fwd_b_ex,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       fwd_cnt
);

    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] rd;
        logic              wr;
        logic              mr;
    } ent_t;

    ent_t             r_ent [DEPTH];
    logic [SEL_W-1:0] r_fwd_a;
    logic [SEL_W-1:0] r_fwd_b;
    logic [SEL_W-1:0] w_sel_a;
    logic [SEL_W-1:0] w_sel_b;
    logic             w_m0_a;
    logic             w_m0_b;
    logic             w_stall;
    logic             w_adv;

    // x0 is never a real producer, so it can never match.
    function automatic logic f_match(ent_t e, logic [REG_AW-1:0] src, logic used, logic vld);
        return vld && used && e.vld && e.wr && (e.rd == src) && (src != '0);
    endfunction

    // The oldest entry is left out of the search: the register file write-through covers it.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int j = DEPTH - 2; j >= 0; j--) begin
            if (f_match(r_ent[j], id_rs1, id_rs1_used, id_valid)) w_sel_a = SEL_W'(j + 1);
            if (f_match(r_ent[j], id_rs2, id_rs2_used, id_valid)) w_sel_b = SEL_W'(j + 1);
        end
    end

    assign w_m0_a  = f_match(r_ent[0], id_rs1, id_rs1_used, id_valid);
    assign w_m0_b  = f_match(r_ent[0], id_rs2, id_rs2_used, id_valid);
    assign w_stall = !flush && r_ent[0].mr && (w_m0_a || w_m0_b);
    assign w_adv   = !stall_ext && !flush && !w_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) r_ent[k] <= '0;
            r_fwd_a <= '0;
            r_fwd_b <= '0;
        end else if (!stall_ext) begin
            for (int k = 1; k < DEPTH; k++) r_ent[k] <= r_ent[k-1];
            if (w_adv) begin
                r_ent[0] <= '{vld: id_valid, rd: id_rd, wr: id_reg_write, mr: id_mem_read};
                r_fwd_a  <= w_sel_a;
                r_fwd_b  <= w_sel_b;
            end else begin
                r_ent[0] <= '0;
                r_fwd_a  <= '0;
                r_fwd_b  <= '0;
            end
        end
    end

    assign stall    = w_stall;
    assign fwd_a_ex = r_fwd_a;
    assign fwd_b_ex = r_fwd_b;

`ifdef FWD_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_fwd_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else begin
            if (w_stall && !stall_ext && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_adv && ((w_sel_a != '0) || (w_sel_b != '0)) && (r_fwd_cnt != '1))
                r_fwd_cnt <= r_fwd_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign fwd_cnt   = r_fwd_cnt;
`else
    assign stall_cnt = '0;
    assign fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Randomized plus directed bench for forwarding_scoreboard against a pipeline reference model.
module tb_forwarding_scoreboard;
    localparam int AW = 5;
    localparam int D  = 3;
    localparam int SW = 3;
    localparam longint CMAX = 64'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_mem_read;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic          stall_ext, flush;
    logic          stall;
    logic [SW-1:0] fwd_a_ex, fwd_b_ex;
    logic [31:0]   stall_cnt, fwd_cnt;

    always #5 clk = ~clk;

    forwarding_scoreboard #(.REG_AW(AW), .DEPTH(D), .SEL_W(SW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .stall_ext(stall_ext),
        .flush(flush), .stall(stall), .fwd_a_ex(fwd_a_ex), .fwd_b_ex(fwd_b_ex),
        .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
    );

    // Reference pipeline: one record per in-flight instruction, index 0 = EX.
    typedef struct {
        bit v;
        int rd;
        bit wr;
        bit mr;
    } ment_t;

    ment_t  m [D];
    int     m_fa, m_fb;
    longint m_sc, m_fc;
    int     n_chk = 0;
    int     n_pass = 0;
    bit     obs_stall;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    function automatic void m_reset();
        for (int k = 0; k < D; k++) begin
            m[k].v = 0; m[k].rd = 0; m[k].wr = 0; m[k].mr = 0;
        end
        m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0;
    endfunction

    function automatic bit mmatch(int k, int s, bit used);
        return id_valid && used && m[k].v && m[k].wr && (m[k].rd == s) && (s != 0);
    endfunction

    function automatic int msel(int s, bit used);
        for (int k = 0; k < D - 1; k++) if (mmatch(k, s, used)) return k + 1;
        return 0;
    endfunction

    function automatic bit mstall();
        return !flush && m[0].mr &&
               (mmatch(0, int'(id_rs1), id_rs1_used) || mmatch(0, int'(id_rs2), id_rs2_used));
    endfunction

    // One clock: check the combinational stall, clock the DUT and model, check registered outputs.
    task automatic step();
        bit st;
        int na, nb;
        #1;
        st = mstall();
        obs_stall = stall;
        chk("stall", stall, st);
        na = msel(int'(id_rs1), id_rs1_used);
        nb = msel(int'(id_rs2), id_rs2_used);
        @(posedge clk);
        if (!stall_ext) begin
`ifdef FWD_PERF_EN
            if (st && m_sc != CMAX) m_sc++;
`endif
            for (int k = D - 1; k > 0; k--) m[k] = m[k-1];
            if (flush || st) begin
                m[0].v = 0; m[0].rd = 0; m[0].wr = 0; m[0].mr = 0;
                m_fa = 0; m_fb = 0;
            end else begin
                m[0].v = id_valid; m[0].rd = int'(id_rd);
                m[0].wr = id_reg_write; m[0].mr = id_mem_read;
                m_fa = na; m_fb = nb;
`ifdef FWD_PERF_EN
                if ((na != 0 || nb != 0) && m_fc != CMAX) m_fc++;
`endif
            end
        end
        #1;
        chk("fwd_a", fwd_a_ex, m_fa);
        chk("fwd_b", fwd_b_ex, m_fb);
        chk("stall_cnt", stall_cnt, m_sc);
        chk("fwd_cnt", fwd_cnt, m_fc);
    endtask

    task automatic set_id(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                          input int rd, input bit wr, input bit mr);
        id_valid = v; id_rs1 = AW'(r1); id_rs1_used = u1; id_rs2 = AW'(r2); id_rs2_used = u2;
        id_rd = AW'(rd); id_reg_write = wr; id_mem_read = mr;
        flush = 0; stall_ext = 0;
    endtask

    task automatic drain();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (D) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        m_reset();
        #2;
        chk("rst_stall", stall, 0);
        chk("rst_fwd_a", fwd_a_ex, 0);
        chk("rst_fwd_b", fwd_b_ex, 0);
        chk("rst_scnt", stall_cnt, 0);
        chk("rst_fcnt", fwd_cnt, 0);
        @(negedge clk);
        rst = 0;

        // ALU producer followed by consumer
        set_id(1, 1, 1, 2, 1, 5, 1, 0); step();
        set_id(1, 5, 1, 3, 1, 8, 1, 0); step();
        chk("alu_fwd_a", fwd_a_ex, 1);
        chk("alu_nostall", obs_stall, 0);
        drain();

        // load-use: one stall cycle, then forward from WB
        set_id(1, 1, 1, 0, 0, 6, 1, 1); step();
        set_id(1, 2, 1, 6, 1, 9, 1, 0); step();
        chk("lu_stall", obs_stall, 1);
        step();
        chk("lu_stall_gone", obs_stall, 0);
        chk("lu_fwd_b", fwd_b_ex, 2);
        drain();

        // youngest producer wins
        set_id(1, 0, 0, 0, 0, 7, 1, 0); step();
        set_id(1, 0, 0, 0, 0, 7, 1, 0); step();
        set_id(1, 7, 1, 0, 0, 4, 1, 0); step();
        chk("young_fwd_a", fwd_a_ex, 1);
        drain();

        // x0 never forwards
        set_id(1, 0, 0, 0, 0, 0, 1, 1); step();
        set_id(1, 0, 1, 0, 1, 3, 1, 0); step();
        chk("x0_fwd_a", fwd_a_ex, 0);
        chk("x0_nostall", obs_stall, 0);
        drain();

        // load-use held by stall_ext, then released
        set_id(1, 0, 0, 0, 0, 9, 1, 1); step();
        set_id(1, 9, 1, 0, 0, 11, 1, 0);
        stall_ext = 1;
        repeat (3) step();
        stall_ext = 0;
        step();
        chk("ext_release_stall", obs_stall, 1);
        step();
        chk("ext_fwd_a", fwd_a_ex, 2);
        drain();

        // reset asserted during a load-use stall
        set_id(1, 0, 0, 0, 0, 10, 1, 1); step();
        set_id(1, 0, 0, 10, 1, 12, 1, 0);
        #1;
        chk("pre_rst_stall", stall, 1);
        rst = 1;
        #1;
        m_reset();
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_fwd_a", fwd_a_ex, 0);
        chk("mid_rst_fwd_b", fwd_b_ex, 0);
        chk("mid_rst_scnt", stall_cnt, 0);
        chk("mid_rst_fcnt", fwd_cnt, 0);
        rst = 0;
        step();
        chk("post_rst_nostall", obs_stall, 0);
        chk("post_rst_fwd_b", fwd_b_ex, 0);

        // randomized traffic over a small register window to provoke hazards
        for (int i = 0; i < 500; i++) begin
            set_id($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
                   $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            stall_ext = ($urandom_range(0, 11) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
